hook_position_ctrl: RTL and testbench

- Sequential source of the fishing hook position that the VGA color stage reads.
- Converts player buttons and a fish-hit event into frame-rate hook motion.
- Outputs h_position/v_position in fixed point: tenths of a pixel; the renderer divides by 10.
- Owns the cast / drop / hold / reel / caught state machine and reports a one-cycle catch pulse to the score logic.

---
 rtl/game_pkg.sv | 19 +
 rtl/tick_gen.sv | 24 ++
 rtl/hook_position_ctrl.sv | 116 +++++++++++
 tb/tb_hook_position_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game constants: hook/line geometry in tenths of a pixel and the hook FSM encoding.
// The color stage imports the same values for the line anchor row/column.
package game_pkg;

  localparam int GAME_SCALE    = 10;
  localparam int GAME_H_HOOK   = 2580;
  localparam int GAME_V_TOP    = 720;
  localparam int GAME_V_BOTTOM = 4700;
  localparam int POS_W         = 14;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DROP   = 3'd1,
    ST_HOLD   = 3'd2,
    ST_REEL   = 3'd3,
    ST_CAUGHT = 3'd4
  } hook_state_e;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
// Shared by the hook and fish motion logic so both move on the same frame cadence.
module tick_gen #(
  parameter int TICK_DIV = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int                CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)           cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CNT_W'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/hook_position_ctrl.sv
// Hook position source for the renderer: cast/drop/hold/reel/caught FSM moving the hook
// vertically on motion ticks, with positions in tenths of a pixel.
module hook_position_ctrl
  import game_pkg::*;
#(
  parameter int TICK_DIV    = 1000000,
  parameter int H_HOOK      = GAME_H_HOOK,
  parameter int V_TOP       = GAME_V_TOP,
  parameter int V_BOTTOM    = GAME_V_BOTTOM,
  parameter int DROP_STEP   = 30,
  parameter int REEL_STEP   = 20,
  parameter int HOOKED_STEP = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cast,
  input  logic        reel,
  input  logic        fish_hit,
  output logic [13:0] h_position,
  output logic [13:0] v_position,
  output logic [2:0]  state,
  output logic        hooked,
  output logic        caught
);

  localparam logic signed [14:0] V_TOP_S  = 15'(V_TOP);
  localparam logic signed [14:0] V_BOT_S  = 15'(V_BOTTOM);
  localparam logic signed [14:0] DROP_S   = 15'(DROP_STEP);
  localparam logic signed [14:0] REEL_S   = 15'(REEL_STEP);
  localparam logic signed [14:0] HOOKED_S = 15'(HOOKED_STEP);
  localparam logic [13:0]        V_TOP_U  = 14'(V_TOP);
  localparam logic [13:0]        V_BOT_U  = 14'(V_BOTTOM);

  hook_state_e       state_q, state_d;
  logic [13:0]       v_q, v_d;
  logic              hooked_q, hooked_d;
  logic              tick;
  logic signed [14:0] v_ext;
  logic signed [14:0] up_step;

  function automatic logic [13:0] clamp_v(input logic signed [14:0] x);
    if (x < V_TOP_S)      return V_TOP_U;
    else if (x > V_BOT_S) return V_BOT_U;
    else                  return x[13:0];
  endfunction

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign v_ext   = $signed({1'b0, v_q});
  assign up_step = hooked_q ? HOOKED_S : REEL_S;

  always_comb begin
    state_d  = state_q;
    v_d      = v_q;
    hooked_d = hooked_q;
    case (state_q)
      ST_IDLE: begin
        v_d = V_TOP_U;
        if (cast) state_d = ST_DROP;
      end
      ST_DROP: begin
        if (tick) v_d = clamp_v(v_ext + DROP_S);
        if (reel)                 state_d = ST_REEL;
        else if (v_d == V_BOT_U)  state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (reel) state_d = ST_REEL;
      end
      ST_REEL: begin
        if (reel) begin
          if (tick) v_d = clamp_v(v_ext - up_step);
          if (v_d == V_TOP_U) state_d = hooked_q ? ST_CAUGHT : ST_IDLE;
        end else if (hooked_q) begin
          // The fish fights back while the player lets go of the reel.
          if (tick) v_d = clamp_v(v_ext + REEL_S);
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_CAUGHT: begin
        hooked_d = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A hit racing a return to IDLE/CAUGHT is dropped so no stale fish survives the catch.
    if (fish_hit && !hooked_q &&
        (state_q == ST_DROP || state_q == ST_HOLD || state_q == ST_REEL) &&
        state_d != ST_IDLE && state_d != ST_CAUGHT)
      hooked_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      v_q      <= V_TOP_U;
      hooked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      v_q      <= v_d;
      hooked_q <= hooked_d;
    end
  end

  assign h_position = 14'(H_HOOK);
  assign v_position = v_q;
  assign state      = state_q;
  assign hooked     = hooked_q;
  assign caught     = (state_q == ST_CAUGHT);

endmodule

// File: tb/tb_hook_position_ctrl.sv
// Directed bench for hook_position_ctrl with TICK_DIV=4 and default steps.
module tb_hook_position_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cast = 1'b0;
  logic        reel = 1'b0;
  logic        fish_hit = 1'b0;
  logic [13:0] h_position, v_position;
  logic [2:0]  state;
  logic        hooked, caught;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hook_position_ctrl #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cast       (cast),
    .reel       (reel),
    .fish_hit   (fish_hit),
    .h_position (h_position),
    .v_position (v_position),
    .state      (state),
    .hooked     (hooked),
    .caught     (caught)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_v(input int target, input int budget, output bit ok);
    int n = 0;
    while (int'(v_position) != target && n < budget) begin
      cyc();
      n++;
    end
    ok = (int'(v_position) == target);
  endtask

  task automatic test_reset();
    int seen = 0;
    rst_n = 1'b0; cast = 1'b0; reel = 1'b0; fish_hit = 1'b0;
    repeat (3) cyc();
    total++; if (v_position !== 14'd720)  begin bad++; $display("FAIL reset_v: got %0d want 720", v_position); end
    total++; if (h_position !== 14'd2580) begin bad++; $display("FAIL reset_h: got %0d want 2580", h_position); end
    total++; if (state !== 3'd0)          begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
    total++; if (hooked !== 1'b0)         begin bad++; $display("FAIL reset_hooked: got %0b want 0", hooked); end
    total++; if (caught !== 1'b0)         begin bad++; $display("FAIL reset_caught: got %0b want 0", caught); end
    rst_n = 1'b1;
    repeat (20) begin
      cyc();
      if (caught !== 1'b0) seen++;
    end
    total++; if (seen != 0)              begin bad++; $display("FAIL idle_caught: got %0d pulses want 0", seen); end
    total++; if (v_position !== 14'd720) begin bad++; $display("FAIL idle_v: got %0d want 720", v_position); end
    total++; if (state !== 3'd0)         begin bad++; $display("FAIL idle_state: got %0d want 0", state); end
  endtask

  task automatic test_drop();
    int ticks = 0, maxv = 0, n = 0, p, e;
    cast = 1'b1; cyc(); cast = 1'b0;
    total++; if (state !== 3'd1)         begin bad++; $display("FAIL drop_enter: got %0d want 1", state); end
    total++; if (v_position !== 14'd720) begin bad++; $display("FAIL drop_start_v: got %0d want 720", v_position); end
    while (state === 3'd1 && n < 800) begin
      p = int'(v_position);
      cyc(); n++;
      if (int'(v_position) != p) begin
        ticks++;
        e = (p + 30 > 4700) ? 4700 : p + 30;
        if (int'(v_position) > maxv) maxv = int'(v_position);
        total++; if (int'(v_position) != e) begin bad++; $display("FAIL drop_step: got %0d want %0d", v_position, e); end
      end
    end
    total++; if (ticks != 133)            begin bad++; $display("FAIL drop_ticks: got %0d want 133", ticks); end
    total++; if (maxv > 4700)             begin bad++; $display("FAIL drop_max: got %0d want <=4700", maxv); end
    total++; if (v_position !== 14'd4700) begin bad++; $display("FAIL drop_bottom: got %0d want 4700", v_position); end
    total++; if (state !== 3'd2)          begin bad++; $display("FAIL drop_hold: got %0d want 2", state); end
    repeat (8) cyc();
    total++; if (v_position !== 14'd4700) begin bad++; $display("FAIL hold_v: got %0d want 4700", v_position); end
  endtask

  task automatic test_reel_empty();
    int n = 0, p, e, seen = 0;
    reel = 1'b1;
    while (int'(v_position) != 4000 && n < 400) begin
      p = int'(v_position);
      cyc(); n++;
      if (int'(v_position) != p) begin
        total++; if (int'(v_position) != p - 20) begin bad++; $display("FAIL reel_step: got %0d want %0d", v_position, p - 20); end
      end
    end
    total++; if (v_position !== 14'd4000) begin bad++; $display("FAIL reel_reach4000: got %0d want 4000", v_position); end
    reel = 1'b0; cyc();
    total++; if (state !== 3'd2)          begin bad++; $display("FAIL reel_release_state: got %0d want 2", state); end
    repeat (10) cyc();
    total++; if (v_position !== 14'd4000) begin bad++; $display("FAIL reel_release_v: got %0d want 4000", v_position); end
    reel = 1'b1; n = 0;
    while (state !== 3'd0 && n < 1000) begin
      p = int'(v_position);
      cyc(); n++;
      if (caught !== 1'b0) seen++;
      if (int'(v_position) != p) begin
        e = (p - 20 < 720) ? 720 : p - 20;
        total++; if (int'(v_position) != e) begin bad++; $display("FAIL reel_up_step: got %0d want %0d", v_position, e); end
      end
    end
    reel = 1'b0;
    total++; if (state !== 3'd0)         begin bad++; $display("FAIL reel_idle: got %0d want 0", state); end
    total++; if (v_position !== 14'd720) begin bad++; $display("FAIL reel_top: got %0d want 720", v_position); end
    total++; if (seen != 0)              begin bad++; $display("FAIL reel_caught: got %0d pulses want 0", seen); end
  endtask

  task automatic test_catch();
    bit ok;
    int n = 0, p, seen = 0;
    cast = 1'b1; cyc(); cast = 1'b0;
    wait_v(1500, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL catch_reach1500: got %0d want 1500", v_position); end
    fish_hit = 1'b1; cyc(); fish_hit = 1'b0;
    total++; if (hooked !== 1'b1) begin bad++; $display("FAIL catch_hooked: got %0b want 1", hooked); end
    total++; if (state !== 3'd1)  begin bad++; $display("FAIL catch_state_kept: got %0d want 1", state); end
    fish_hit = 1'b1; cyc(); fish_hit = 1'b0;
    total++; if (hooked !== 1'b1) begin bad++; $display("FAIL catch_second_hit: got %0b want 1", hooked); end
    total++; if (state !== 3'd1)  begin bad++; $display("FAIL catch_second_state: got %0d want 1", state); end
    reel = 1'b1; cyc();
    total++; if (state !== 3'd3)  begin bad++; $display("FAIL catch_reel: got %0d want 3", state); end
    while (state !== 3'd0 && n < 800) begin
      p = int'(v_position);
      cyc(); n++;
      if (caught === 1'b1) begin
        seen++;
        total++; if (v_position !== 14'd720) begin bad++; $display("FAIL catch_top: got %0d want 720", v_position); end
      end else if (int'(v_position) != p) begin
        total++; if (int'(v_position) != p - 10) begin bad++; $display("FAIL catch_step: got %0d want %0d", v_position, p - 10); end
      end
    end
    reel = 1'b0;
    total++; if (seen != 1)              begin bad++; $display("FAIL catch_pulse: got %0d cycles want 1", seen); end
    total++; if (state !== 3'd0)         begin bad++; $display("FAIL catch_idle: got %0d want 0", state); end
    total++; if (hooked !== 1'b0)        begin bad++; $display("FAIL catch_unhook: got %0b want 0", hooked); end
    total++; if (v_position !== 14'd720) begin bad++; $display("FAIL catch_v: got %0d want 720", v_position); end
    cyc();
    total++; if (caught !== 1'b0)        begin bad++; $display("FAIL catch_after: got %0b want 0", caught); end
  endtask

  task automatic test_fish_pull();
    bit ok;
    int n = 0, p, ticks = 0;
    cast = 1'b1; cyc(); cast = 1'b0;
    wait_v(2010, 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL pull_reach2010: got %0d want 2010", v_position); end
    fish_hit = 1'b1; reel = 1'b1; cyc(); fish_hit = 1'b0;
    total++; if (hooked !== 1'b1) begin bad++; $display("FAIL pull_hooked: got %0b want 1", hooked); end
    total++; if (state !== 3'd3)  begin bad++; $display("FAIL pull_reel: got %0d want 3", state); end
    wait_v(2000, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL pull_reach2000: got %0d want 2000", v_position); end
    reel = 1'b0;
    while (ticks < 5 && n < 100) begin
      p = int'(v_position);
      cyc(); n++;
      if (int'(v_position) != p) begin
        ticks++;
        total++; if (int'(v_position) != p + 20) begin bad++; $display("FAIL pull_step: got %0d want %0d", v_position, p + 20); end
      end
    end
    total++; if (v_position !== 14'd2100) begin bad++; $display("FAIL pull_v: got %0d want 2100", v_position); end
    total++; if (state !== 3'd3)          begin bad++; $display("FAIL pull_state: got %0d want 3", state); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    wait_v(3000, 400, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_reach3000: got %0d want 3000", v_position); end
    total++; if (state !== 3'd3) begin bad++; $display("FAIL mid_pre_state: got %0d want 3", state); end
    rst_n = 1'b0; cyc();
    total++; if (v_position !== 14'd720) begin bad++; $display("FAIL mid_v: got %0d want 720", v_position); end
    total++; if (state !== 3'd0)         begin bad++; $display("FAIL mid_state: got %0d want 0", state); end
    total++; if (hooked !== 1'b0)        begin bad++; $display("FAIL mid_hooked: got %0b want 0", hooked); end
    rst_n = 1'b1; cyc();
  endtask

  task automatic test_conflicts();
    int n = 0, p;
    fish_hit = 1'b1; reel = 1'b1; cyc(); fish_hit = 1'b0; reel = 1'b0;
    total++; if (state !== 3'd0)  begin bad++; $display("FAIL idle_ignore_state: got %0d want 0", state); end
    total++; if (hooked !== 1'b0) begin bad++; $display("FAIL idle_ignore_hit: got %0b want 0", hooked); end
    cast = 1'b1; cyc(); cast = 1'b0;
    repeat (5) cyc();
    p = int'(v_position);
    cast = 1'b1; cyc(); cast = 1'b0;
    total++; if (state !== 3'd1) begin bad++; $display("FAIL drop_cast_state: got %0d want 1", state); end
    total++; if (int'(v_position) != p && int'(v_position) != p + 30)
      begin bad++; $display("FAIL drop_cast_v: got %0d want %0d or %0d", v_position, p, p + 30); end
    reel = 1'b1; cyc();
    total++; if (state !== 3'd3) begin bad++; $display("FAIL drop_reel_prio: got %0d want 3", state); end
    while (state !== 3'd0 && n < 200) begin cyc(); n++; end
    reel = 1'b0;
    total++; if (v_position !== 14'd720) begin bad++; $display("FAIL early_reel_top: got %0d want 720", v_position); end
    total++; if (state !== 3'd0)         begin bad++; $display("FAIL early_reel_idle: got %0d want 0", state); end
  endtask

  initial begin
    test_reset();
    test_drop();
    test_reel_empty();
    test_catch();
    test_fish_pull();
    test_mid_reset();
    test_conflicts();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
